// File: rtl/fec_rx_deframer.sv
// Serial-to-parallel deframer feeding the cross-parity FEC decoder.
// Optional decoder-done watchdog enabled by defining FEC_DEFRAMER_TIMEOUT_EN.
module fec_rx_deframer #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sof,
    input  logic                          in_data,
    output logic [WIDTH-1:0][DEPTH-1:0]   dec_data,
    output logic [DEPTH-1:0]              dec_row_parity,
    output logic [WIDTH-1:0]              dec_col_parity,
    output logic                          dec_start,
    input  logic                          dec_done,
    output logic                          busy,
    output logic                          frame_err,
    output logic [15:0]                   frame_cnt
`ifdef FEC_DEFRAMER_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    localparam int DATA_BITS = WIDTH * DEPTH;
    localparam int N         = DATA_BITS + DEPTH + WIDTH;
    localparam int CNT_W     = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        START,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [N-1:0]     frame_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;

`ifdef FEC_DEFRAMER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] wd_cnt;
`endif

    assign accept = in_valid && in_ready;

    // The whole frame lives in one shift-free register; fields are fixed slices of it.
    assign dec_data       = frame_q[DATA_BITS-1:0];
    assign dec_row_parity = frame_q[DATA_BITS +: DEPTH];
    assign dec_col_parity = frame_q[DATA_BITS+DEPTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_q   <= '0;
            bit_cnt   <= '0;
            in_ready  <= 1'b0;
            dec_start <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
`ifdef FEC_DEFRAMER_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            dec_start <= 1'b0;
            frame_err <= 1'b0;
`ifdef FEC_DEFRAMER_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept && in_sof) begin
                        frame_q[0] <= in_data;
                        bit_cnt    <= ONE;
                        busy       <= 1'b1;
                        state      <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        // A mid-frame sof restarts assembly rather than completing the frame.
                        if (in_sof) begin
                            frame_err  <= 1'b1;
                            frame_q[0] <= in_data;
                            bit_cnt    <= ONE;
                        end else begin
                            frame_q[bit_cnt] <= in_data;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt   <= '0;
                                in_ready  <= 1'b0;
                                dec_start <= 1'b1;
                                state     <= START;
                            end else begin
                                bit_cnt <= bit_cnt + ONE;
                            end
                        end
                    end
                end

                START: begin
                    state <= WAIT_DONE;
`ifdef FEC_DEFRAMER_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end

                WAIT_DONE: begin
                    if (dec_done) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                        if (frame_cnt != 16'hFFFF) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
`ifdef FEC_DEFRAMER_TIMEOUT_EN
                    else if (wd_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + TO_W'(1);
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fec_rx_deframer.sv
// Randomized, self-checking bench for fec_rx_deframer (4x4 block, 24-bit frames).
// Exercises the FEC_DEFRAMER_TIMEOUT_EN watchdog when that macro is defined.
module tb_fec_rx_deframer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int N     = WIDTH * DEPTH + DEPTH + WIDTH;
`ifdef FEC_DEFRAMER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_sof;
    logic                        in_data;
    logic [WIDTH-1:0][DEPTH-1:0] dec_data;
    logic [DEPTH-1:0]            dec_row_parity;
    logic [WIDTH-1:0]            dec_col_parity;
    logic                        dec_start;
    logic                        dec_done;
    logic                        busy;
    logic                        frame_err;
    logic [15:0]                 frame_cnt;
`ifdef FEC_DEFRAMER_TIMEOUT_EN
    logic                        timeout_err;
`endif

    int checks = 0;
    int failures = 0;
    int start_seen = 0;
    int err_seen = 0;
    int overlap_seen = 0;
    int exp_start = 0;
    int exp_err = 0;
    int exp_cnt = 0;
    logic [15:0] exp_data;
    logic [3:0]  exp_row;
    logic [3:0]  exp_col;

    fec_rx_deframer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sof(in_sof),
        .in_data(in_data),
        .dec_data(dec_data),
        .dec_row_parity(dec_row_parity),
        .dec_col_parity(dec_col_parity),
        .dec_start(dec_start),
        .dec_done(dec_done),
        .busy(busy),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
`ifdef FEC_DEFRAMER_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (dec_start) start_seen++;
        if (frame_err) err_seen++;
        if (dec_start && frame_err) overlap_seen++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_data"}, 32'(dec_data), 32'(exp_data));
        checkOutput({tag, "_row"}, 32'(dec_row_parity), 32'(exp_row));
        checkOutput({tag, "_col"}, 32'(dec_col_parity), 32'(exp_col));
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_data"}, 32'(dec_data), 32'h0);
        checkOutput({tag, "_rowcol"}, 32'({dec_row_parity, dec_col_parity}), 32'h0);
        checkOutput({tag, "_flags"}, 32'({in_ready, dec_start, busy, frame_err}), 32'h0);
        checkOutput({tag, "_cnt"}, 32'(frame_cnt), 32'h0);
    endtask

    // Offer one bit, waiting out back-pressure; returns one negedge after acceptance.
    task automatic applyStimulus(input logic sof, input logic d, input int gap_pct);
        int guard = 0;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("ready_wait", 32'(guard), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic sendBits(input logic [N-1:0] fb, input int nbits, input int gap_pct);
        for (int k = 0; k < nbits; k++) begin
            applyStimulus(k == 0, fb[k], gap_pct);
            if (k == 0) checkOutput("busy_set", 32'(busy), 32'd1);
        end
    endtask

    // The reference frame: data lsb first, then row parity, then column parity.
    task automatic sendFrame(input logic [15:0] d, input logic [3:0] r, input logic [3:0] c,
                             input int gap_pct);
        sendBits({c, r, d}, N, gap_pct);
        exp_data = d;
        exp_row  = r;
        exp_col  = c;
        exp_start++;
        checkOutput("start_pulse", 32'(dec_start), 32'd1);
        checkOutput("ready_in_start", 32'(in_ready), 32'd0);
    endtask

    // Entered in the dec_start cycle; decoder answers 'delay' cycles later.
    task automatic finishFrame(input int delay, input string tag);
        for (int i = 0; i < delay; i++) begin
            checkOutput("ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("ready_low", 32'(in_ready), 32'd0);
        checkFrame({tag, "_held"});
        dec_done = 1'b1;
        @(negedge clk);
        dec_done = 1'b0;
        if (exp_cnt < 65535) exp_cnt++;
        checkOutput("ready_back", 32'(in_ready), 32'd1);
        checkOutput("busy_clear", 32'(busy), 32'd0);
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        checkFrame(tag);
    endtask

    initial begin
        logic [N-1:0] junk;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 1'b0;
        dec_done = 1'b0;
        repeat (3) @(negedge clk);
        checkZero("reset");
`ifdef FEC_DEFRAMER_TIMEOUT_EN
        checkOutput("reset_timeout", 32'(timeout_err), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

        $display("[TB] directed frame A5C3/6/9");
        sendFrame(16'hA5C3, 4'h6, 4'h9, 0);
        finishFrame(3, "directed");

        $display("[TB] stray dec_done while idle");
        dec_done = 1'b1;
        @(negedge clk);
        dec_done = 1'b0;
        @(negedge clk);
        checkOutput("stray_done_cnt", 32'(frame_cnt), 32'(exp_cnt));

        $display("[TB] leading bits without sof");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'($urandom), 0);
        checkOutput("idle_discard_busy", 32'(busy), 32'd0);
        sendFrame(16'($urandom), 4'($urandom), 4'($urandom), 0);
        finishFrame(2, "after_junk");
        checkOutput("no_frame_err", 32'(err_seen), 32'(exp_err));

        $display("[TB] sof restart at bit 10");
        junk = N'({$urandom, $urandom});
        sendBits(junk, 10, 0);
        exp_err++;
        sendFrame(16'($urandom), 4'($urandom), 4'($urandom), 0);
        finishFrame(4, "restart");
        checkOutput("restart_err", 32'(err_seen), 32'(exp_err));
        checkOutput("restart_starts", 32'(start_seen), 32'(exp_start));

        $display("[TB] three frames with random gaps");
        for (int f = 0; f < 3; f++) begin
            sendFrame(16'($urandom), 4'($urandom), 4'($urandom), 50);
            finishFrame(int'($urandom_range(1, 5)), "gapped");
        end

        $display("[TB] reset in COLLECT at bit 15");
        sendBits(N'({$urandom, $urandom}), 15, 0);
        rst_n = 1'b0;
        #1;
        checkZero("reset_collect");
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst1", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("no_start_rst1", 32'(start_seen), 32'(exp_start));

        $display("[TB] reset in WAIT_DONE");
        sendFrame(16'($urandom), 4'($urandom), 4'($urandom), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkZero("reset_wait");
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst2", 32'(in_ready), 32'd1);
        sendFrame(16'($urandom), 4'($urandom), 4'($urandom), 25);
        finishFrame(3, "post_reset");

`ifdef FEC_DEFRAMER_TIMEOUT_EN
        $display("[TB] watchdog expiry");
        sendFrame(16'($urandom), 4'($urandom), 4'($urandom), 0);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            checkOutput("timeout_early", 32'(timeout_err), 32'd0);
        end
        @(negedge clk);
        checkOutput("timeout_pulse", 32'(timeout_err), 32'd1);
        checkOutput("timeout_ready", 32'(in_ready), 32'd1);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        checkOutput("timeout_cnt", 32'(frame_cnt), 32'(exp_cnt));

        $display("[TB] dec_done on the last watchdog cycle");
        sendFrame(16'($urandom), 4'($urandom), 4'($urandom), 0);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            if (i == TO) dec_done = 1'b1;
        end
        @(negedge clk);
        dec_done = 1'b0;
        exp_cnt++;
        checkOutput("done_wins_timeout", 32'(timeout_err), 32'd0);
        checkOutput("done_wins_cnt", 32'(frame_cnt), 32'(exp_cnt));
`endif

        repeat (2) @(negedge clk);
        checkOutput("total_starts", 32'(start_seen), 32'(exp_start));
        checkOutput("total_errs", 32'(err_seen), 32'(exp_err));
        checkOutput("start_err_overlap", 32'(overlap_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
